// File: rtl/alu_seq_if.sv
// alu_seq_if: host-side program/control bus and ALU drive bus of the ALU program sequencer
interface alu_seq_if #(
    parameter int ADDR_W = 3,
    parameter int LOOP_W = 4
);
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [9:0]        prog_data;
    logic [ADDR_W-1:0] prog_last;
    logic [LOOP_W-1:0] loops;
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic [15:0]       result;
    logic              alu_rst_n;
    logic [1:0]        alu_inst;
    logic [7:0]        alu_a;
    logic [15:0]       alu_out;
    modport master (
        output prog_we, prog_addr, prog_data, prog_last, loops, start, abort, alu_out,
        input  busy, done, result, alu_rst_n, alu_inst, alu_a
    );
    modport slave (
        input  prog_we, prog_addr, prog_data, prog_last, loops, start, abort, alu_out,
        output busy, done, result, alu_rst_n, alu_inst, alu_a
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: program sequencer that clears the ALU, replays a stored program for N passes and captures the result
module alu_seq #(
    parameter int ADDR_W = 3,
    parameter int LOOP_W = 4
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CLR, RUN, WAIT} state_t;
    state_t            r_state;
    logic [9:0]        r_mem [2**ADDR_W];
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_last;
    logic [LOOP_W-1:0] r_loops;
    logic [LOOP_W-1:0] r_pass;
    logic              r_done;
    logic [15:0]       r_result;
    logic [9:0]        w_entry;
    assign w_entry       = r_mem[r_pc];
    assign bus.busy      = r_state != IDLE;
    assign bus.done      = r_done;
    assign bus.result    = r_result;
    assign bus.alu_rst_n = r_state != CLR;
    assign bus.alu_inst  = r_state == RUN ? w_entry[9:8] : 2'b00;
    assign bus.alu_a     = r_state == RUN ? w_entry[7:0] : 8'h00;
    // sequencer FSM, program store and result capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_pc     <= '0;
            r_last   <= '0;
            r_loops  <= '0;
            r_pass   <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
            for (int i = 0; i < 2**ADDR_W; i++) r_mem[i] <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.prog_we && r_state == IDLE) r_mem[bus.prog_addr] <= bus.prog_data;
            case (r_state)
                IDLE: if (bus.start && !bus.abort) begin
                    r_last  <= bus.prog_last;
                    r_loops <= bus.loops == '0 ? LOOP_W'(1) : bus.loops;
                    r_pc    <= '0;
                    r_pass  <= LOOP_W'(1);
                    r_state <= CLR;
                end
                CLR: r_state <= bus.abort ? IDLE : RUN;
                RUN: if (bus.abort) r_state <= IDLE;
                    else if (r_pc < r_last) r_pc <= r_pc + 1'b1;
                    else if (r_pass < r_loops) begin
                        r_pc   <= '0;
                        r_pass <= r_pass + 1'b1;
                    end else r_state <= WAIT;
                WAIT: begin
                    r_state <= IDLE;
                    if (!bus.abort) begin
                        r_result <= bus.alu_out;
                        r_done   <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of the ALU sequencer against a behavioural accumulator ALU
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [15:0] acc = '0;
    int n_vec = 0;
    int n_err = 0;
    alu_seq_if #(.ADDR_W(3), .LOOP_W(4)) bus ();
    alu_seq #(.ADDR_W(3), .LOOP_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    assign bus.alu_out = acc;
    // reference accumulator ALU: 00 ADD, 01 SUB, 10 MUL, 11 AND
    always @(posedge clk) begin
        if (!bus.alu_rst_n) acc <= '0;
        else case (bus.alu_inst)
            2'b00: acc <= acc + {8'h00, bus.alu_a};
            2'b01: acc <= acc - {8'h00, bus.alu_a};
            2'b10: acc <= 16'(acc * {8'h00, bus.alu_a});
            default: acc <= acc & {8'h00, bus.alu_a};
        endcase
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic load(input logic [2:0] addr, input logic [1:0] inst, input logic [7:0] a);
        bus.prog_we = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = {inst, a};
        @(negedge clk);
        bus.prog_we = 1'b0;
    endtask
    task automatic run(input string tag, input logic [2:0] last, input logic [3:0] lp,
                       input int exp_cyc, input logic [15:0] exp_res, input bit disturb);
        int cnt = 0;
        int clr = 0;
        bit early = 1'b0;
        bus.prog_last = last;
        bus.loops = lp;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (bus.busy && cnt < 400) begin
            cnt++;
            if (!bus.alu_rst_n) clr++;
            if (bus.done) early = 1'b1;
            if (disturb && cnt == 1) begin
                bus.start = 1'b1;
                bus.prog_we = 1'b1;
                bus.prog_addr = 3'd0;
                bus.prog_data = {2'b00, 8'd9};
            end else begin
                bus.start = 1'b0;
                bus.prog_we = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, cnt, exp_cyc);
        chk({tag, "_clr_cycles"}, clr, 1);
        chk({tag, "_done_early"}, {31'd0, early}, 0);
        chk({tag, "_done"}, {31'd0, bus.done}, 1);
        chk({tag, "_result"}, {16'd0, bus.result}, {16'd0, exp_res});
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, {31'd0, bus.done}, 0);
        chk({tag, "_result_held"}, {16'd0, bus.result}, {16'd0, exp_res});
    endtask
    initial begin
        bus.prog_we = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.prog_last = '0;
        bus.loops = '0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_done", {31'd0, bus.done}, 0);
        chk("rst_result", {16'd0, bus.result}, 0);
        chk("rst_alu_rst_n", {31'd0, bus.alu_rst_n}, 1);
        chk("rst_alu_issue", {22'd0, bus.alu_inst, bus.alu_a}, 0);
        rst = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort_busy", {31'd0, bus.busy}, 0);
        load(3'd0, 2'b00, 8'd5);
        load(3'd1, 2'b00, 8'd3);
        load(3'd2, 2'b10, 8'd4);
        run("t1", 3'd2, 4'd1, 5, 16'd32, 1'b0);
        load(3'd0, 2'b00, 8'd1);
        run("t2a", 3'd0, 4'd10, 12, 16'd10, 1'b0);
        run("t2b", 3'd0, 4'd0, 3, 16'd1, 1'b0);
        load(3'd0, 2'b00, 8'hFF);
        load(3'd1, 2'b10, 8'hFF);
        run("t3", 3'd1, 4'd2, 6, 16'h0100, 1'b0);
        load(3'd0, 2'b01, 8'd1);
        load(3'd1, 2'b11, 8'h0F);
        run("t4", 3'd1, 4'd1, 4, 16'h000F, 1'b0);
        run("t5", 3'd1, 4'd1, 4, 16'h000F, 1'b1);
        bus.prog_last = 3'd1;
        bus.loops = 4'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("ab_run1_issue", {22'd0, bus.alu_inst, bus.alu_a}, {22'd0, 2'b01, 8'd1});
        @(negedge clk);
        chk("ab_run2_issue", {22'd0, bus.alu_inst, bus.alu_a}, {22'd0, 2'b11, 8'h0F});
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("ab_busy", {31'd0, bus.busy}, 0);
        chk("ab_done", {31'd0, bus.done}, 0);
        chk("ab_result", {16'd0, bus.result}, 16'h000F);
        chk("ab_issue", {22'd0, bus.alu_inst, bus.alu_a}, 0);
        @(negedge clk);
        chk("ab_no_late_done", {31'd0, bus.done}, 0);
        bus.prog_last = 3'd1;
        bus.loops = 4'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mrst_busy", {31'd0, bus.busy}, 0);
        chk("mrst_done", {31'd0, bus.done}, 0);
        chk("mrst_result", {16'd0, bus.result}, 0);
        run("t6", 3'd7, 4'd1, 10, 16'd0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Program sequencer for the 8-bit-operand / 16-bit-accumulator ALU.
- Holds a small loadable program of {inst, a} entries. On start it clears the ALU accumulator, then issues one entry per cycle for a programmed number of passes.
- Captures the final accumulator value, pulses done, and holds the ALU with no-ops (ADD 0) whenever idle.
- Sits between the host/control logic and the ALU instance and owns the ALU's inst, a and rst inputs.

Parameters:
- ADDR_W, 3, program address width; program depth = 2**ADDR_W entries.
- LOOP_W, 4, width of the pass-count input.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset, synchronous, active-low.
- prog_we  input  1  program write strobe.
- prog_addr  input  ADDR_W  program write address.
- prog_data  input  10  program entry: [9:8]=inst, [7:0]=a.
- prog_last  input  ADDR_W  index of last entry to execute; sampled on start.
- loops  input  LOOP_W  number of passes over entries 0..prog_last; sampled on start; 0 treated as 1.
- start  input  1  begin execution; honoured only in IDLE.
- abort  input  1  cancel execution.
- busy  output  1  high in CLR, RUN, WAIT.
- done  output  1  one-cycle pulse when result is updated.
- result  output  16  final accumulator value of the last completed run.
- alu_rst_n  output  1  to ALU rst; low only in CLR.
- alu_inst  output  2  to ALU inst.
- alu_a  output  8  to ALU a.
- alu_out  input  16  from ALU out.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; busy=0, done=0, result=0.
  - All program entries cleared to 10'h000 (ADD 0).
  - Pass counter and pc cleared.
- Outputs alu_inst/alu_a/alu_rst_n are combinational from state and pc:
  - RUN: entry[pc].
  - Every other state: alu_inst=00, alu_a=0 (no-op).
  - alu_rst_n=0 only in CLR.
- Program write: at posedge with prog_we=1 and state=IDLE, entry[prog_addr]<=prog_data. Writes while busy are ignored.
- State IDLE:
  - start=1 at posedge latches prog_last and loops (0→1), pc<=0, pass counter<=1, state<=CLR.
  - start with abort=1 in the same cycle: abort wins, stay IDLE.
- State CLR (1 cycle): alu_rst_n=0, so the ALU accumulator is 0 after this edge. Next state RUN.
- State RUN: issues entry[pc] each cycle; the ALU applies it at the closing edge.
  - If pc<last: pc<=pc+1.
  - Else if pass<loops: pc<=0, pass<=pass+1.
  - Else: state<=WAIT.
- State WAIT (1 cycle): no-op issued; alu_out holds the final value. At the edge: result<=alu_out, done<=1, state<=IDLE.
- done is high exactly one cycle (the first IDLE cycle after WAIT), coincident with the new result. result is held until the next completed run.
- Latency: start sampled at edge E0 → done high in the cycle after edge E0+2+(prog_last+1)*loops. busy is high for the same 2+(prog_last+1)*loops cycles.
- abort=1 at posedge in CLR/RUN/WAIT:
  - state<=IDLE, no done pulse, result unchanged.
  - The ALU accumulator retains its partial value, which is harmless: the next run starts with CLR.
- start while busy: ignored.
- All arithmetic wrap-around (overflow, underflow, multiply truncation to 16 bits) is the ALU's. The sequencer adds no checks.
- rst mid-run: immediate return to reset values. Any in-flight run is lost, with no done pulse.

Test Plan:
- Load [ADD 5, ADD 3, MUL 4], prog_last=2, loops=1, start → busy for 5 cycles; done pulse after edge E0+5; result=16'd32; alu_rst_n low exactly one cycle.
- Load [ADD 1], prog_last=0, loops=10, start → done after edge E0+12; result=16'd10. Repeat with loops=0 → result=16'd1, done after E0+3.
- Load [ADD 8'hFF, MUL 8'hFF], prog_last=1, loops=2 → pass1 value 16'd65025; final result=16'h0100 (multiply wrap).
- Load [SUB 1, AND 8'h0F], prog_last=1, loops=1 → SUB step gives 16'hFFFF; final result=16'h000F.
- During a run: pulse start and prog_we (entry 0 ← ADD 9) → both ignored, run completes with the old program. Next run: abort asserted in the 2nd RUN cycle → busy=0 next cycle, no done, result keeps the previous value, alu_inst/alu_a = 00/0.
- rst=0 for one edge mid-run → busy=0, done=0, result=0. Then start with prog_last=7, loops=1 → result=0 (cleared program), done after edge E0+10.
